tty_tx_fifo: RTL and testbench



---
 rtl/tty_tx_fifo.sv | 161 ++++++++++++++++
 tb/tb_tty_tx_fifo.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/tty_tx_fifo.sv
// rtl/tty_tx_fifo.sv - bus-slave stdout FIFO with built-in 8N1 serializer
// Optional TTY_TX_FIFO_DROP_EN: full DATA writes are acked and dropped, counted in STATUS[23:16].
module tty_tx_fifo #(
  parameter logic [31:0] BASE       = 32'h3000,
  parameter int          DEPTH_LOG2 = 4,
  parameter int          DIV        = 868
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic [31:0] addr,
  input  logic [2:0]  size,
  input  logic        valid,
  input  logic        write,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        tx
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int BW    = $clog2(DIV);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                state_q, state_d;
  logic [BW-1:0]         baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [7:0]            shift_q, shift_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]            mem_q [DEPTH];

  logic       hit_d, hit_s, wr_data_req;
  logic       full, empty, busy;
  logic       push, pop, baud_wrap, data_ready;
  logic [7:0] drop_cnt;
  logic       unused_bits;

  assign unused_bits = ^{size, wdata[31:8]};

  assign hit_d       = (addr == BASE);
  assign hit_s       = (addr == BASE + 32'd4);
  assign wr_data_req = valid && write && hit_d;
  assign full        = (count_q == FULL_CNT);
  assign empty       = (count_q == '0);
  assign busy        = (state_q != S_IDLE);
  assign push        = wr_data_req && !full;
  assign baud_wrap   = (baud_q == BAUD_LAST);
  // Back-to-back frames: the next byte is taken on the last STOP cycle.
  assign pop         = !empty && ((state_q == S_IDLE) || (state_q == S_STOP && baud_wrap));

`ifdef TTY_TX_FIFO_DROP_EN
  logic [7:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (wr_data_req && full && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) drop_q <= 8'd0;
    else       drop_q <= drop_d;
  end

  assign drop_cnt   = drop_q;
  assign data_ready = valid;
`else
  assign drop_cnt   = 8'd0;
  assign data_ready = valid && !full;
`endif

  always_comb begin
    ready = 1'b0;
    rdata = 32'd0;
    if (hit_s) begin
      ready = valid;
      if (valid && !write)
        rdata = {8'd0, drop_cnt, 8'(count_q), 5'd0, busy, empty, full};
    end else if (hit_d) begin
      ready = write ? data_ready : valid;
    end
  end

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    if (state_q != S_IDLE) baud_d = baud_wrap ? '0 : baud_q + BW'(1);

    case (state_q)
      S_START: if (baud_wrap) begin
        state_d = S_DATA;
        bit_d   = 3'd0;
      end
      S_DATA: if (baud_wrap) begin
        shift_d = shift_q >> 1;
        if (bit_q == 3'd7) state_d = S_STOP;
        else               bit_d   = bit_q + 3'd1;
      end
      S_STOP: if (baud_wrap) state_d = S_IDLE;
      default: ;
    endcase

    if (pop) begin
      state_d  = S_START;
      baud_d   = '0;
      shift_d  = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    end
    if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase
  end

  always_comb begin
    case (state_q)
      S_START: tx = 1'b0;
      S_DATA:  tx = shift_q[0];
      default: tx = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'd0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata[7:0];
  end

endmodule

// File: tb/tb_tty_tx_fifo.sv
// tb/tb_tty_tx_fifo.sv - directed scoreboard bench for tty_tx_fifo (DIV=4, depth 4)
module tb_tty_tx_fifo;

  localparam logic [31:0] BASE = 32'h3000;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [2:0]  size = 3'd0;
  logic        valid = 1'b0;
  logic        write = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        ready;
  logic        tx;

  tty_tx_fifo #(.BASE(BASE), .DEPTH_LOG2(2), .DIV(4)) dut (
    .clk(clk), .rstb(rstb), .addr(addr), .size(size), .valid(valid),
    .write(write), .wdata(wdata), .rdata(rdata), .ready(ready), .tx(tx)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  int         starts[$];
  int         cyc = 0;
  bit         mon_busy = 1'b0;
  int         mon_off = 0;
  logic [7:0] mon_byte = 8'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $display("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, expv);
      $error("%s", tag);
    end
  endtask

  function automatic logic [31:0] status_val(input int cnt, input bit bsy, input int drops);
    logic [7:0] c8;
    logic [7:0] d8;
    c8 = 8'(cnt);
    d8 = 8'(drops);
    return {8'd0, d8, c8, 5'd0, bsy, (cnt == 0), (cnt == 4)};
  endfunction

  // 8N1 receiver: offset 0 is the first start-bit cycle, bit centres at 4k+2.
  always @(negedge clk) begin
    cyc++;
    if (!rstb) begin
      mon_busy = 1'b0;
    end else if (!mon_busy) begin
      if (tx === 1'b0) begin
        mon_busy = 1'b1;
        mon_off  = 0;
        starts.push_back(cyc);
      end
    end else begin
      mon_off++;
      if (mon_off == 2) check("rx_start_bit", tx, 0);
      if (mon_off >= 6 && mon_off <= 34 && (mon_off % 4) == 2)
        mon_byte[(mon_off - 6) / 4] = tx;
      if (mon_off == 38) begin
        check("rx_stop_bit", tx, 1);
        check("rx_byte_pending", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("rx_byte", mon_byte, exp_q.pop_front());
        mon_busy = 1'b0;
      end
    end
  end

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic r);
    addr  = a;
    write = 1'b0;
    valid = 1'b1;
    @(negedge clk);
    d = rdata;
    r = ready;
    @(posedge clk);
    #1;
    valid = 1'b0;
    addr  = 32'd0;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [7:0] d, input bit keep, output int stall);
    bit got;
    got   = 1'b0;
    stall = 0;
    addr  = a;
    write = 1'b1;
    wdata = {24'hC0FFEE, d};
    valid = 1'b1;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (ready === 1'b1) got = 1'b1;
      else stall++;
      @(posedge clk);
      #1;
    end
    check("wr_handshake", got, 1);
    if (got && keep && a == BASE) exp_q.push_back(d);
    valid = 1'b0;
    write = 1'b0;
    addr  = 32'd0;
  endtask

  task automatic wait_drain();
    int i;
    for (i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !mon_busy) break;
    end
    check("drain_timeout", i < 2000, 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int          st;
    int          n0;
    int          drops;
    logic [31:0] rd;
    logic        rr;
    drops = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", tx, 1);
    check("rst_ready", ready, 0);
    check("rst_rdata", rdata, 0);
    rstb = 1'b1;
    @(posedge clk);
    #1;

    bus_read(BASE + 32'd4, rd, rr);
    check("status_empty", rd, 32'h2);
    check("status_ready", rr, 1);
    bus_read(BASE, rd, rr);
    check("data_read_zero", rd, 0);
    check("data_read_ready", rr, 1);
    bus_read(BASE + 32'd8, rd, rr);
    check("unmapped_rd_rdata", rd, 0);
    check("unmapped_rd_ready", rr, 0);

    addr = BASE + 32'd8; write = 1'b1; wdata = 32'h77; valid = 1'b1;
    @(negedge clk);
    check("unmapped_wr_ready", ready, 0);
    @(posedge clk);
    #1;
    addr = BASE + 32'd4;
    @(negedge clk);
    check("status_wr_ready", ready, 1);
    @(posedge clk);
    #1;
    valid = 1'b0; write = 1'b0; addr = 32'd0;
    bus_read(BASE + 32'd4, rd, rr);
    check("fifo_unchanged", rd, status_val(0, 0, 0));

    bus_write(BASE, 8'h55, 1, st);
    check("w55_no_stall", st, 0);
    @(negedge clk);
    check("tx_idle_after_push", tx, 1);
    @(negedge clk);
    check("tx_start_latency", tx, 0);
    @(posedge clk);
    #1;
    repeat (8) @(posedge clk);
    #1;
    bus_read(BASE + 32'd4, rd, rr);
    check("status_busy", rd, status_val(0, 1, 0));
    wait_drain();
    bus_read(BASE + 32'd4, rd, rr);
    check("status_after_55", rd, status_val(0, 0, 0));

    n0 = starts.size();
    bus_write(BASE, 8'h41, 1, st);
    bus_write(BASE, 8'h42, 1, st);
    wait_drain();
    check("b2b_frames", starts.size() - n0, 2);
    if (starts.size() >= n0 + 2) check("b2b_gap", starts[n0 + 1] - starts[n0], 40);

    for (int i = 0; i < 5; i++) begin
      bus_write(BASE, 8'hA0 + 8'(i), 1, st);
      check("fill_no_stall", st, 0);
    end
    bus_read(BASE + 32'd4, rd, rr);
    check("status_full", rd, status_val(4, 1, 0));
`ifdef TTY_TX_FIFO_DROP_EN
    bus_write(BASE, 8'hA5, 0, st);
    check("drop_no_stall", st, 0);
    drops = 1;
    bus_read(BASE + 32'd4, rd, rr);
    check("status_drop", rd, status_val(4, 1, drops));
`else
    bus_write(BASE, 8'hA5, 1, st);
    check("full_stall_len", (st >= 30 && st <= 45), 1);
`endif
    wait_drain();
    bus_read(BASE + 32'd4, rd, rr);
    check("status_after_fill", rd, status_val(0, 0, drops));

    bus_write(BASE, 8'h00, 1, st);
    repeat (18) @(posedge clk);
    #2;
    check("pre_reset_tx_low", tx, 0);
    rstb = 1'b0;
    exp_q.delete();
    #1;
    check("reset_tx_async", tx, 1);
    repeat (2) @(posedge clk);
    #1;
    rstb = 1'b1;
    @(posedge clk);
    #1;
    n0 = starts.size();
    bus_read(BASE + 32'd4, rd, rr);
    check("status_after_reset", rd, status_val(0, 0, 0));
    repeat (60) @(posedge clk);
    #1;
    check("no_residual_frame", starts.size() - n0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
